// File: rtl/apu_mixer_pkg.sv
// Shared types and widths for the APU output mixer.
// APU_MIXER_VIN_EN adds the cartridge VIN source as a fifth accumulate slot.
package apu_mixer_pkg;

  typedef enum logic [1:0] {IDLE, ACC, SCALE} state_e;

`ifdef APU_MIXER_VIN_EN
  localparam int NCH = 5;
`else
  localparam int NCH = 4;
`endif
  localparam int ACC_W = 7;
  localparam int OUT_W = 10;
  localparam int VOL_W = 3;
  localparam int SMP_W = 4;
  localparam int IDX_W = $clog2(NCH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  // Everything a frame reads after its start edge comes from this copy.
  typedef struct packed {
    logic [NCH-1:0][SMP_W-1:0] smp;
    logic [NCH-1:0]            en;
    logic [NCH-1:0]            lm;
    logic [NCH-1:0]            rm;
    logic [VOL_W-1:0]          lvol;
    logic [VOL_W-1:0]          rvol;
  } snap_t;

  // Volume code 0..7 means gain 1..8; 75*8 still fits OUT_W.
  function automatic logic [OUT_W-1:0] scale(input logic [ACC_W-1:0] acc,
                                             input logic [VOL_W-1:0] vol);
    return OUT_W'(acc) * (OUT_W'(vol) + OUT_W'(1));
  endfunction

endpackage

// File: rtl/apu_sample_div.sv
// Divides the 1 MHz tick down to the output frame rate; frame_start pulses on wrap.
// Held at zero while the APU is off.
module apu_sample_div #(
  parameter int SAMPLE_DIV = 4
) (
  input  logic apuv_4mhz,
  input  logic napu_reset,
  input  logic tick_1mhz,
  input  logic apu_on,
  output logic frame_start
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap        = tick_1mhz && (cnt == LAST);
  assign frame_start = apu_on && wrap;

  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset)     cnt <= '0;
    else if (!apu_on)    cnt <= '0;
    else if (tick_1mhz)  cnt <= wrap ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/apu_mixer.sv
// APU left/right mixer: snapshots sources at frame start, accumulates one channel per
// clock, then applies NR50 volume. APU_MIXER_VIN_EN adds the VIN input and one extra step.
module apu_mixer
  import apu_mixer_pkg::*;
#(
  parameter int SAMPLE_DIV = 4
) (
  input  logic             apuv_4mhz,
  input  logic             napu_reset,
  input  logic             tick_1mhz,
  input  logic             apu_on,
  input  logic [SMP_W-1:0] ch1,
  input  logic [SMP_W-1:0] ch2,
  input  logic [SMP_W-1:0] ch3,
  input  logic [SMP_W-1:0] ch4,
  input  logic [3:0]       dac_en,
  input  logic [3:0]       lmixer,
  input  logic [3:0]       rmixer,
  input  logic [VOL_W-1:0] lvol,
  input  logic [VOL_W-1:0] rvol,
`ifdef APU_MIXER_VIN_EN
  input  logic [SMP_W-1:0] vin,
  input  logic             vin_l_en,
  input  logic             vin_r_en,
`endif
  output logic [OUT_W-1:0] lout,
  output logic [OUT_W-1:0] rout,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  state_e                    state, state_nxt;
  snap_t                     snap, snap_in;
  logic                      frame_start, pend, start, ovr_set;
  logic [IDX_W-1:0]          idx;
  logic [ACC_W-1:0]          lacc, racc;
  logic [NCH-1:0][SMP_W-1:0] gated;
  logic [SMP_W-1:0]          cur;

  apu_sample_div #(.SAMPLE_DIV(SAMPLE_DIV)) u_div (
    .apuv_4mhz   (apuv_4mhz),
    .napu_reset  (napu_reset),
    .tick_1mhz   (tick_1mhz),
    .apu_on      (apu_on),
    .frame_start (frame_start)
  );

  always_comb begin
    snap_in          = '0;
    snap_in.smp[3:0] = {ch4, ch3, ch2, ch1};
    snap_in.en[3:0]  = dac_en;
    snap_in.lm[3:0]  = lmixer;
    snap_in.rm[3:0]  = rmixer;
    snap_in.lvol     = lvol;
    snap_in.rvol     = rvol;
`ifdef APU_MIXER_VIN_EN
    snap_in.smp[4]   = vin;
    snap_in.en[4]    = 1'b1;
    snap_in.lm[4]    = vin_l_en;
    snap_in.rm[4]    = vin_r_en;
`endif
  end

  // A disabled DAC contributes silence regardless of its sample value.
  for (genvar i = 0; i < NCH; i++) begin : g_gate
    assign gated[i] = snap.en[i] ? snap.smp[i] : '0;
  end
  assign cur = gated[idx];

  // A wrap that lands on the SCALE edge is held one cycle; it survives only if tick stays high.
  assign start   = apu_on && (state == IDLE) && (frame_start || (pend && tick_1mhz));
  assign ovr_set = apu_on && ((frame_start && (state == ACC)) ||
                              ((state == IDLE) && pend && !tick_1mhz));
  assign busy    = (state != IDLE);

  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!apu_on) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = ACC;
        ACC:     if (idx == LAST_IDX) state_nxt = SCALE;
        SCALE:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      snap      <= '0;
      lacc      <= '0;
      racc      <= '0;
      idx       <= '0;
      lout      <= '0;
      rout      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      pend      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      pend      <= 1'b0;
      if (!apu_on) begin
        lout <= '0;
        rout <= '0;
        idx  <= '0;
      end else begin
        pend <= frame_start && (state == SCALE);
        if (ovr_set) overrun <= 1'b1;
        case (state)
          IDLE: begin
            if (start) begin
              snap <= snap_in;
              lacc <= '0;
              racc <= '0;
              idx  <= '0;
            end
          end
          ACC: begin
            if (snap.lm[idx]) lacc <= lacc + ACC_W'(cur);
            if (snap.rm[idx]) racc <= racc + ACC_W'(cur);
            idx <= idx + IDX_W'(1);
          end
          SCALE: begin
            lout      <= scale(lacc, snap.lvol);
            rout      <= scale(racc, snap.rvol);
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apu_mixer.sv
// Scoreboard bench for apu_mixer: expected mixes are queued at each frame start edge and
// checked (value and latency) when out_valid fires. Build with APU_MIXER_VIN_EN for the VIN case.
`timescale 1ns/1ps
module tb_apu_mixer;

  localparam int DIV = 4;
`ifdef APU_MIXER_VIN_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, apu_on = 1'b0;
  logic [3:0] ch [4];
  logic [3:0] dac_en, lmixer, rmixer;
  logic [2:0] lvol, rvol;
`ifdef APU_MIXER_VIN_EN
  logic [3:0] vin;
  logic       vin_l_en, vin_r_en;
`endif
  logic [9:0] lout, rout;
  logic       out_valid, busy, overrun;

  typedef struct {
    logic [9:0] l;
    logic [9:0] r;
    int         e0;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0, fails = 0, cyc = 0, tcnt = 0, last_e0 = -100;
  int   last_vld = -1, prev_vld = -1;

  apu_mixer #(.SAMPLE_DIV(DIV)) dut (
    .apuv_4mhz  (clk),
    .napu_reset (rst_n),
    .tick_1mhz  (tick),
    .apu_on     (apu_on),
    .ch1        (ch[0]),
    .ch2        (ch[1]),
    .ch3        (ch[2]),
    .ch4        (ch[3]),
    .dac_en     (dac_en),
    .lmixer     (lmixer),
    .rmixer     (rmixer),
    .lvol       (lvol),
    .rvol       (rvol),
`ifdef APU_MIXER_VIN_EN
    .vin        (vin),
    .vin_l_en   (vin_l_en),
    .vin_r_en   (vin_r_en),
`endif
    .lout       (lout),
    .rout       (rout),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference mix computed from the inputs present at the start edge.
  task automatic start_frame(input int e0);
    exp_t e;
    int   la, ra;
    logic [3:0] s;
    if (e0 < last_e0 + LAT + 1) return;
    la = 0;
    ra = 0;
    for (int i = 0; i < 4; i++) begin
      s = dac_en[i] ? ch[i] : 4'd0;
      if (lmixer[i]) la += int'(s);
      if (rmixer[i]) ra += int'(s);
    end
`ifdef APU_MIXER_VIN_EN
    if (vin_l_en) la += int'(vin);
    if (vin_r_en) ra += int'(vin);
`endif
    e.l  = 10'(la * (int'(lvol) + 1));
    e.r  = 10'(ra * (int'(rvol) + 1));
    e.e0 = e0;
    sb.push_back(e);
    last_e0 = e0;
  endtask

  // One clock of stimulus; tracks the expected divider so frame starts are predicted.
  task automatic clk_tick(input logic t);
    @(negedge clk);
    tick = t;
    if (!apu_on) begin
      tcnt = 0;
    end else if (t) begin
      if (tcnt == DIV - 1) begin
        tcnt = 0;
        start_frame(cyc + 1);
      end else begin
        tcnt++;
      end
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      clk_tick(1'b1);
      repeat (3) clk_tick(1'b0);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      clk_tick(1'b0);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d frames outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic set_case2();
    ch[0] = 4'd15; ch[1] = 4'd0; ch[2] = 4'd7; ch[3] = 4'd3;
    dac_en = 4'hF; lmixer = 4'b0101; rmixer = 4'hF;
    lvol = 3'd7; rvol = 3'd0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid) begin
      prev_vld = last_vld;
      last_vld = cyc;
      if (sb.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL unexpected_valid: out_valid at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        vectors += 3;
        if (lout !== e.l) begin
          fails++;
          $display("FAIL lout: got %0d, required %0d", lout, e.l);
        end
        if (rout !== e.r) begin
          fails++;
          $display("FAIL rout: got %0d, required %0d", rout, e.r);
        end
        if (cyc - e.e0 !== LAT) begin
          fails++;
          $display("FAIL latency: got %0d clocks, required %0d", cyc - e.e0, LAT);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({lout, rout} !== 20'd0) begin
      fails++;
      $display("FAIL reset_out: got %0d/%0d, required 0/0", lout, rout);
    end
    vectors++;
    if ({out_valid, busy, overrun} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 000", {out_valid, busy, overrun});
    end
    rst_n = 1'b1;
    apu_on = 1'b1;
    set_case2();
    run_ticks(4);
    wait_drain();
    // Abort a frame two edges in with an asynchronous reset.
    run_ticks(3);
    clk_tick(1'b1);
    clk_tick(1'b0);
    clk_tick(1'b0);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({lout, rout, out_valid, busy} !== 22'd0) begin
      fails++;
      $display("FAIL reset_async: got lout=%0d rout=%0d v=%b busy=%b, required zeros",
               lout, rout, out_valid, busy);
    end
    sb.delete();
    tcnt = 0;
    last_e0 = -100;
    clk_tick(1'b0);
    clk_tick(1'b0);
    rst_n = 1'b1;
    repeat (10) clk_tick(1'b0);
    run_ticks(4);
    wait_drain();
  endtask

  task automatic test_basic();
    set_case2();
    run_ticks(3);
    clk_tick(1'b1);
    clk_tick(1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    wait_drain();
    clk_tick(1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL valid_single: got %b, required 0", out_valid);
    end
  endtask

  task automatic test_snapshot();
    set_case2();
    run_ticks(3);
    clk_tick(1'b1);
    clk_tick(1'b0);
    ch[0] = 4'd0;
    lvol  = 3'd0;
    repeat (2) clk_tick(1'b0);
    wait_drain();
    run_ticks(4);
    wait_drain();
    vectors++;
    if (lout !== 10'd7) begin
      fails++;
      $display("FAIL snapshot_next: got %0d, required 7", lout);
    end
  endtask

  task automatic test_dac_gate();
    ch[0] = 4'd15; ch[1] = 4'd5; ch[2] = 4'd5; ch[3] = 4'd5;
    dac_en = 4'b1110; lmixer = 4'h1; rmixer = 4'hF;
    lvol = 3'd3; rvol = 3'd1;
    run_ticks(4);
    wait_drain();
    vectors++;
    if (lout !== 10'd0) begin
      fails++;
      $display("FAIL dac_gate: got %0d, required 0", lout);
    end
  endtask

  task automatic test_apu_off();
    set_case2();
    run_ticks(4);
    wait_drain();
    run_ticks(3);
    clk_tick(1'b1);
    repeat (2) clk_tick(1'b0);
    apu_on = 1'b0;
    sb.delete();
    clk_tick(1'b0);
    vectors++;
    if ({lout, rout, busy} !== 21'd0) begin
      fails++;
      $display("FAIL apu_off: got lout=%0d rout=%0d busy=%b, required zeros", lout, rout, busy);
    end
    repeat (3) begin
      clk_tick(1'b1);
      clk_tick(1'b0);
    end
    apu_on = 1'b1;
    run_ticks(3);
    vectors++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL apu_on_early: busy %b after 3 ticks, required 0", busy);
    end
    clk_tick(1'b1);
    clk_tick(1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL apu_on_start: busy %b after %0d ticks, required 1", busy, DIV);
    end
    wait_drain();
    vectors++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL apu_off_overrun: got %b, required 0", overrun);
    end
  endtask

  task automatic test_rate_overrun();
    ch[0] = 4'd9; ch[1] = 4'd4; ch[2] = 4'd1; ch[3] = 4'd12;
    dac_en = 4'hF; lmixer = 4'b1010; rmixer = 4'b0111;
    lvol = 3'd2; rvol = 3'd5;
    run_ticks(12);
    wait_drain();
    vectors++;
    if (last_vld - prev_vld !== 16) begin
      fails++;
      $display("FAIL valid_period: got %0d clocks, required 16", last_vld - prev_vld);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clean: got %b, required 0", overrun);
    end
    repeat (12) clk_tick(1'b1);
    clk_tick(1'b0);
    wait_drain();
    vectors++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    apu_on = 1'b0;
    clk_tick(1'b0);
    vectors++;
    if ({overrun, lout} !== {1'b1, 10'd0}) begin
      fails++;
      $display("FAIL overrun_sticky: got ovr=%b lout=%0d, required ovr=1 lout=0", overrun, lout);
    end
    apu_on = 1'b1;
  endtask

`ifdef APU_MIXER_VIN_EN
  task automatic test_vin();
    ch[0] = 4'd3; ch[1] = 4'd6; ch[2] = 4'd2; ch[3] = 4'd8;
    dac_en = 4'hF; lmixer = 4'h0; rmixer = 4'h0;
    lvol = 3'd1; rvol = 3'd0;
    vin = 4'd10; vin_l_en = 1'b1; vin_r_en = 1'b0;
    run_ticks(4);
    wait_drain();
    vectors++;
    if (lout !== 10'd20) begin
      fails++;
      $display("FAIL vin_lout: got %0d, required 20", lout);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) ch[i] = 4'd0;
    dac_en = 4'h0; lmixer = 4'h0; rmixer = 4'h0;
    lvol = 3'd0; rvol = 3'd0;
`ifdef APU_MIXER_VIN_EN
    vin = 4'd0; vin_l_en = 1'b0; vin_r_en = 1'b0;
`endif
    test_reset();
    test_basic();
    test_snapshot();
    test_dac_gate();
    test_apu_off();
    test_rate_overrun();
`ifdef APU_MIXER_VIN_EN
    test_vin();
`endif
    repeat (4) clk_tick(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
